// File: rtl/z80_bus_pkg.sv
// -----------------------------------------------------------------------------
// z80_bus_pkg
// Shared types and default constants for the sound Z80 bus controller.
//   fetch_state_t : ROM fetch sequencer states
//   bus_state_t   : nBUSRQ/nBUSAK arbiter states
//   ROM_TOP_DEF   : first address not served by the ROM fetch path
//   TIMEOUT_DEF   : CLK cycles a fetch waits for ROM_ACK before giving up
//   TW_DEF        : width of the fetch timeout counter
// -----------------------------------------------------------------------------
package z80_bus_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_FETCH,
        F_HOLD
    } fetch_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_REQ,
        B_GNT,
        B_REL
    } bus_state_t;

    localparam logic [15:0] ROM_TOP_DEF = 16'hF800;
    localparam int          TIMEOUT_DEF = 255;
    localparam int          TW_DEF      = 8;

endpackage

// File: rtl/z80_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// z80_bus_ctrl_if
// Groups the Z80 strobes, the ROM fetch port and the auxiliary bus-request
// handshake seen by z80_bus_ctrl.
//   slave  : view used by the controller (strobes/acks in, wait/request out)
//   master : view used by whatever drives the Z80/memory/aux side
// -----------------------------------------------------------------------------
interface z80_bus_ctrl_if;
    logic [15:0] SDA;
    logic        nMREQ;
    logic        nRD;
    logic        nBUSAK;
    logic        nWAIT;
    logic        nBUSRQ;
    logic        ROM_REQ;
    logic [15:0] ROM_ADDR;
    logic        ROM_ACK;
    logic [7:0]  ROM_DATA;
    logic [7:0]  ROM_DOUT;
    logic        AUX_REQ;
    logic        AUX_GNT;
    logic        ERR;

    modport slave (
        input  SDA, nMREQ, nRD, nBUSAK, ROM_ACK, ROM_DATA, AUX_REQ,
        output nWAIT, nBUSRQ, ROM_REQ, ROM_ADDR, ROM_DOUT, AUX_GNT, ERR
    );

    modport master (
        output SDA, nMREQ, nRD, nBUSAK, ROM_ACK, ROM_DATA, AUX_REQ,
        input  nWAIT, nBUSRQ, ROM_REQ, ROM_ADDR, ROM_DOUT, AUX_GNT, ERR
    );
endinterface

// File: rtl/z80_busrq_arb.sv
// -----------------------------------------------------------------------------
// z80_busrq_arb
// Hands the Z80 bus to one auxiliary master through nBUSRQ/nBUSAK.
//   CLK, nRESET : clock, asynchronous active-low reset
//   nBUSAK      : Z80 bus acknowledge (in)
//   AUX_REQ     : level request from the auxiliary master (in)
//   nBUSRQ      : bus request to the Z80 (out, registered)
//   AUX_GNT     : auxiliary master owns the bus (out, registered)
// -----------------------------------------------------------------------------
module z80_busrq_arb
    import z80_bus_pkg::*;
(
    input  logic CLK,
    input  logic nRESET,
    input  logic nBUSAK,
    input  logic AUX_REQ,
    output logic nBUSRQ,
    output logic AUX_GNT
);

    bus_state_t state_q, state_d;
    logic       nbusrq_q, nbusrq_d;
    logic       gnt_q, gnt_d;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= B_IDLE;
            nbusrq_q <= 1'b1;
            gnt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nbusrq_q <= nbusrq_d;
            gnt_q    <= gnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nbusrq_d = nbusrq_q;
        gnt_d    = gnt_q;
        case (state_q)
            B_IDLE: begin
                if (AUX_REQ) begin
                    nbusrq_d = 1'b0;
                    state_d  = B_REQ;
                end
            end
            B_REQ: begin
                // A request withdrawn before the ack never produces a grant.
                if (!AUX_REQ) begin
                    nbusrq_d = 1'b1;
                    state_d  = B_REL;
                end else if (!nBUSAK) begin
                    gnt_d   = 1'b1;
                    state_d = B_GNT;
                end
            end
            B_GNT: begin
                if (!AUX_REQ) begin
                    gnt_d    = 1'b0;
                    nbusrq_d = 1'b1;
                    state_d  = B_REL;
                end
            end
            B_REL: begin
                // Wait for the Z80 to take the bus back before re-arming.
                if (nBUSAK) begin
                    state_d = B_IDLE;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    assign nBUSRQ  = nbusrq_q;
    assign AUX_GNT = gnt_q;

endmodule

// File: rtl/z80_bus_ctrl.sv
// -----------------------------------------------------------------------------
// z80_bus_ctrl
// Stretches Z80 ROM reads with nWAIT while an external memory fetches the
// byte, and shares the Z80 bus with an auxiliary master.
//   CLK, nRESET : clock, asynchronous active-low reset
//   bus         : z80_bus_ctrl_if.slave carrying the Z80 strobes (SDA, nMREQ,
//                 nRD, nBUSAK, nWAIT, nBUSRQ), the ROM fetch port (ROM_REQ,
//                 ROM_ADDR, ROM_ACK, ROM_DATA, ROM_DOUT), the aux handshake
//                 (AUX_REQ, AUX_GNT) and the sticky timeout flag ERR
// -----------------------------------------------------------------------------
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] ROM_TOP = ROM_TOP_DEF,
    parameter int          TIMEOUT = TIMEOUT_DEF,
    parameter int          TW      = TW_DEF
) (
    input  logic           CLK,
    input  logic           nRESET,
    z80_bus_ctrl_if.slave  bus
);

    fetch_state_t  state_q, state_d;
    logic [15:0]   rom_addr_q, rom_addr_d;
    logic          rom_req_q, rom_req_d;
    logic          nwait_q, nwait_d;
    logic [7:0]    rom_dout_q, rom_dout_d;
    logic          err_q, err_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rom_hit;
    logic          strobe_on;

    assign strobe_on = ~bus.nMREQ & ~bus.nRD;
    assign rom_hit   = strobe_on & (bus.SDA < ROM_TOP);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= F_IDLE;
            rom_addr_q <= 16'h0000;
            rom_req_q  <= 1'b0;
            nwait_q    <= 1'b1;
            rom_dout_q <= 8'hFF;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_req_q  <= rom_req_d;
            nwait_q    <= nwait_d;
            rom_dout_q <= rom_dout_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rom_req_d  = rom_req_q;
        nwait_d    = nwait_q;
        rom_dout_d = rom_dout_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            F_IDLE: begin
                if (rom_hit) begin
                    rom_addr_d = bus.SDA;
                    rom_req_d  = 1'b1;
                    nwait_d    = 1'b0;
                    cnt_d      = '0;
                    state_d    = F_FETCH;
                end
            end
            F_FETCH: begin
                cnt_d = cnt_q + TW'(1);
                // An ack in the timeout cycle still delivers real data.
                if (bus.ROM_ACK) begin
                    rom_dout_d = bus.ROM_DATA;
                    rom_req_d  = 1'b0;
                    nwait_d    = 1'b1;
                    state_d    = F_HOLD;
                end else if (cnt_q == TW'(TIMEOUT)) begin
                    rom_dout_d = 8'hFF;
                    err_d      = 1'b1;
                    rom_req_d  = 1'b0;
                    nwait_d    = 1'b1;
                    state_d    = F_HOLD;
                end
            end
            F_HOLD: begin
                // Park until the Z80 ends this read so it fetches only once.
                if (!strobe_on) begin
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign bus.nWAIT    = nwait_q;
    assign bus.ROM_REQ  = rom_req_q;
    assign bus.ROM_ADDR = rom_addr_q;
    assign bus.ROM_DOUT = rom_dout_q;
    assign bus.ERR      = err_q;

    z80_busrq_arb u_arb (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .nBUSAK  (bus.nBUSAK),
        .AUX_REQ (bus.AUX_REQ),
        .nBUSRQ  (bus.nBUSRQ),
        .AUX_GNT (bus.AUX_GNT)
    );

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z80_bus_ctrl
// Self-checking bench for z80_bus_ctrl: ROM fetches with random addresses,
// data and ack latencies, non-ROM accesses, timeout, long strobes, bus
// arbitration and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_z80_bus_ctrl;
    import z80_bus_pkg::*;

    localparam int TO = TIMEOUT_DEF;

    logic CLK    = 1'b0;
    logic nRESET = 1'b1;

    z80_bus_ctrl_if bus();

    z80_bus_ctrl dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int checks    = 0;
    int errors    = 0;
    int req_rises = 0;

    // Expected sticky flag and last delivered byte.
    logic       err_exp  = 1'b0;
    logic [7:0] dout_exp = 8'hFF;

    always @(posedge bus.ROM_REQ) req_rises++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic z80_idle();
        bus.SDA      = 16'h0000;
        bus.nMREQ    = 1'b1;
        bus.nRD      = 1'b1;
        bus.ROM_ACK  = 1'b0;
        bus.ROM_DATA = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_nwait"},   bus.nWAIT,    1);
        check({tag, "_nbusrq"},  bus.nBUSRQ,   1);
        check({tag, "_romreq"},  bus.ROM_REQ,  0);
        check({tag, "_romaddr"}, bus.ROM_ADDR, 0);
        check({tag, "_romdout"}, bus.ROM_DOUT, 8'hFF);
        check({tag, "_auxgnt"},  bus.AUX_GNT,  0);
        check({tag, "_err"},     bus.ERR,      0);
    endtask

    // One Z80 ROM read. ack_at = cycle (counted from ROM_REQ rising) in which
    // ROM_ACK is pulsed; 0 means never. hold = extra cycles the strobe stays low.
    task automatic do_fetch(input logic [15:0] addr, input logic [7:0] data,
                            input int ack_at, input int hold);
        int   r0;
        int   n;
        int   exp_n;
        logic done;
        logic ack_ok;
        r0 = req_rises;
        bus.SDA   = addr;
        bus.nMREQ = 1'b0;
        bus.nRD   = 1'b0;
        tick();
        check("fetch_req_on",    bus.ROM_REQ,  1);
        check("fetch_nwait_low", bus.nWAIT,    0);
        check("fetch_addr",      bus.ROM_ADDR, addr);
        // The wait window lasts until the ack, capped at TIMEOUT+1 cycles.
        ack_ok = (ack_at >= 1) && (ack_at <= TO + 1);
        exp_n  = ack_ok ? ack_at : TO + 1;
        n    = 0;
        done = 1'b0;
        while (!done && n < TO + 10) begin
            n++;
            bus.ROM_ACK  = (n == ack_at);
            bus.ROM_DATA = data;
            tick();
            bus.ROM_ACK = 1'b0;
            if (bus.nWAIT === 1'b1) done = 1'b1;
        end
        if (ack_ok) dout_exp = data;
        else begin
            dout_exp = 8'hFF;
            err_exp  = 1'b1;
        end
        check("fetch_wait_cycles", n,            exp_n);
        check("fetch_req_off",     bus.ROM_REQ,  0);
        check("fetch_dout",        bus.ROM_DOUT, dout_exp);
        check("fetch_err",         bus.ERR,      err_exp);
        // Stray acks with junk data while the strobe is held must be ignored.
        for (int h = 0; h < hold; h++) begin
            bus.ROM_ACK  = 1'($urandom_range(0, 1));
            bus.ROM_DATA = ~data;
            tick();
        end
        bus.ROM_ACK = 1'b0;
        check("hold_nwait", bus.nWAIT,    1);
        check("hold_dout",  bus.ROM_DOUT, dout_exp);
        z80_idle();
        tick();
        check("fetch_single_req", req_rises - r0, 1);
    endtask

    // Access that must not start a fetch (write, or address above ROM).
    task automatic non_rom(input logic [15:0] addr, input logic rd_n, input int cycles);
        int r0;
        r0 = req_rises;
        bus.SDA   = addr;
        bus.nMREQ = 1'b0;
        bus.nRD   = rd_n;
        for (int c = 0; c < cycles; c++) begin
            tick();
            check("nonrom_nwait", bus.nWAIT, 1);
        end
        z80_idle();
        tick();
        check("nonrom_no_req", req_rises - r0, 0);
        check("nonrom_dout",   bus.ROM_DOUT,   dout_exp);
    endtask

    initial begin
        z80_idle();
        bus.nBUSAK  = 1'b1;
        bus.AUX_REQ = 1'b0;

        // Reset
        #1 nRESET = 1'b0;
        #2;
        check_reset_vals("rst0");
        tick();
        tick();
        @(negedge CLK);
        nRESET = 1'b1;
        tick();
        check_reset_vals("rst0_rel");

        // Basic fetch and non-ROM accesses
        do_fetch(16'h1234, 8'hA5, 5, 2);
        non_rom(16'hF900, 1'b0, 6);
        non_rom(16'h0100, 1'b1, 6);
        non_rom(16'hF800, 1'b0, 4);
        do_fetch(16'hF7FF, 8'($urandom), 3, 0);

        // Timeout, then a good fetch keeps ERR set
        do_fetch(16'h0200, 8'h00, 0, 1);
        do_fetch(16'h0300, 8'h3C, 4, 1);
        // Ack in the very cycle of the timeout
        do_fetch(16'h0400, 8'h5A, TO + 1, 0);

        // Long strobe then an immediate follow-up read
        do_fetch(16'h0500, 8'($urandom), 2, 50);
        do_fetch(16'h0001, 8'($urandom), 3, 0);

        // Randomized mix
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                non_rom(16'($urandom_range(16'hF800, 16'hFFFF)), 1'($urandom_range(0, 1)),
                        $urandom_range(1, 4));
            else if ($urandom_range(0, 3) == 0)
                non_rom(16'($urandom_range(0, 16'hF7FF)), 1'b1, $urandom_range(1, 4));
            else
                do_fetch(16'($urandom_range(0, 16'hF7FF)), 8'($urandom),
                         $urandom_range(1, 12), $urandom_range(0, 5));
        end

        // Arbitration
        bus.AUX_REQ = 1'b1;
        tick();
        check("arb_busrq_on", bus.nBUSRQ,  0);
        check("arb_no_gnt",   bus.AUX_GNT, 0);
        repeat (2) begin
            tick();
            check("arb_wait_busrq", bus.nBUSRQ,  0);
            check("arb_wait_gnt",   bus.AUX_GNT, 0);
        end
        bus.nBUSAK = 1'b0;
        tick();
        check("arb_gnt",       bus.AUX_GNT, 1);
        check("arb_gnt_busrq", bus.nBUSRQ,  0);
        repeat ($urandom_range(1, 5)) tick();
        check("arb_gnt_hold", bus.AUX_GNT, 1);
        bus.AUX_REQ = 1'b0;
        tick();
        check("arb_rel_gnt",   bus.AUX_GNT, 0);
        check("arb_rel_busrq", bus.nBUSRQ,  1);
        // New request while still released must wait for nBUSAK high.
        bus.AUX_REQ = 1'b1;
        repeat (3) begin
            tick();
            check("arb_rel_wait", bus.nBUSRQ, 1);
        end
        bus.nBUSAK = 1'b1;
        tick();
        check("arb_rel_done", bus.nBUSRQ, 1);
        tick();
        check("arb_rereq", bus.nBUSRQ, 0);
        // Withdraw before acknowledge
        bus.AUX_REQ = 1'b0;
        tick();
        check("arb_wd_busrq", bus.nBUSRQ,  1);
        check("arb_wd_gnt",   bus.AUX_GNT, 0);
        tick();
        tick();
        check("arb_wd_idle_gnt", bus.AUX_GNT, 0);

        // Asynchronous reset mid-grant and mid-fetch
        bus.AUX_REQ = 1'b1;
        tick();
        bus.nBUSAK = 1'b0;
        tick();
        check("rst_pre_gnt", bus.AUX_GNT, 1);
        bus.SDA   = 16'h0600;
        bus.nMREQ = 1'b0;
        bus.nRD   = 1'b0;
        tick();
        check("rst_pre_req", bus.ROM_REQ, 1);
        tick();
        #2 nRESET = 1'b0;
        #1;
        check_reset_vals("rst1");
        tick();
        check_reset_vals("rst1_held");
        z80_idle();
        bus.nBUSAK  = 1'b1;
        bus.AUX_REQ = 1'b0;
        err_exp  = 1'b0;
        dout_exp = 8'hFF;
        @(negedge CLK);
        nRESET = 1'b1;
        tick();
        check_reset_vals("rst1_rel");
        do_fetch(16'h0700, 8'h99, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
